// File: rtl/reg_scoreboard_ctrl_if.sv
// Decode/writeback handshake bundle for the register scoreboard interlock.
// The master side drives the pipeline status; the slave side is the scoreboard.
interface reg_scoreboard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              ds_valid;
  logic [4:0]        ds_rj;
  logic              ds_rj_used;
  logic [4:0]        ds_rkd;
  logic              ds_rkd_used;
  logic [4:0]        ds_dest;
  logic              ds_gr_we;
  logic              es_allowin;
  logic              ws_rf_we;
  logic [4:0]        ws_rf_waddr;
  logic              flush;
  logic              ds_ready_go;
  logic [31:0]       busy_vec;
  logic [PERF_W-1:0] stall_cycles;
  logic              sb_err;

  modport master (
    output ds_valid, ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest, ds_gr_we,
           es_allowin, ws_rf_we, ws_rf_waddr, flush,
    input  ds_ready_go, busy_vec, stall_cycles, sb_err
  );

  modport slave (
    input  ds_valid, ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest, ds_gr_we,
           es_allowin, ws_rf_we, ws_rf_waddr, flush,
    output ds_ready_go, busy_vec, stall_cycles, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Decode-stage issue interlock: per-GPR in-flight write counters gate RAW and
// WAW-overflow hazards, with a stall-cycle counter and a sticky underflow flag.
module reg_scoreboard_ctrl #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input logic                 clk,
  input logic                 resetn,
  reg_scoreboard_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_reg  [32];
  logic [CNT_W-1:0]  cnt_next [32];
  logic [31:0]       busy;
  logic [31:0]       underflow;
  logic [PERF_W-1:0] stall_reg;
  logic              sb_err_reg;
  logic              raw_hz;
  logic              waw_full;
  logic              ready_go;
  logic              issue;
  logic              stall_hit;

  // A register retiring this cycle still reads busy: no retire bypass.
  assign raw_hz    = (bus.ds_rj_used & busy[bus.ds_rj]) | (bus.ds_rkd_used & busy[bus.ds_rkd]);
  assign waw_full  = bus.ds_gr_we & (bus.ds_dest != 5'd0) & (cnt_reg[bus.ds_dest] == CNT_MAX);
  assign ready_go  = ~raw_hz & ~waw_full;
  assign issue     = bus.ds_valid & ready_go & bus.es_allowin & ~bus.flush;
  assign stall_hit = bus.ds_valid & ~ready_go & ~bus.flush;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_r0
        assign cnt_next[gi]  = '0;
        assign busy[gi]      = 1'b0;
        assign underflow[gi] = 1'b0;
      end else begin : g_rn
        logic inc;
        logic dec;
        assign inc           = issue & bus.ds_gr_we & (bus.ds_dest == 5'(gi));
        assign dec           = bus.ws_rf_we & (bus.ws_rf_waddr == 5'(gi)) & ~bus.flush;
        assign busy[gi]      = (cnt_reg[gi] != '0);
        assign underflow[gi] = dec & ~inc & ~busy[gi];
        // Flush wins; a retire of an idle register holds it at zero.
        assign cnt_next[gi]  = bus.flush                 ? '0 :
                               (inc & ~dec)              ? cnt_reg[gi] + CNT_ONE :
                               (dec & ~inc & busy[gi])   ? cnt_reg[gi] - CNT_ONE :
                                                           cnt_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= '0;
      stall_reg  <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= cnt_next[i];
      if (stall_hit && (stall_reg != '1)) stall_reg <= stall_reg + PERF_W'(1);
      if (|underflow) sb_err_reg <= 1'b1;
    end
  end

  assign bus.ds_ready_go  = ready_go;
  assign bus.busy_vec     = busy;
  assign bus.stall_cycles = stall_reg;
  assign bus.sb_err       = sb_err_reg;
endmodule

// File: doc/reg_scoreboard_ctrl.md
Name: reg_scoreboard_ctrl

Overview:
- Issue-interlock controller for the decode stage of the 5-stage LoongArch pipeline.
- Tracks the in-flight register writes between decode issue and writeback retire, using one saturating counter per GPR.
- Decides whether the instruction in decode may advance (ds_ready_go).
- Keeps a debug busy vector, a stall-cycle performance counter and a sticky underflow error flag.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; maximum pending writes per register is 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ds_valid  in  1  decode holds a valid instruction.
- ds_rj  in  5  source-1 register index.
- ds_rj_used  in  1  source-1 is read by this instruction.
- ds_rkd  in  5  source-2 register index (rk or rd, already muxed).
- ds_rkd_used  in  1  source-2 is read.
- ds_dest  in  5  destination register index.
- ds_gr_we  in  1  instruction writes the GPR file.
- es_allowin  in  1  execute stage can accept.
- ws_rf_we  in  1  writeback retires a GPR write this cycle (already qualified by ws valid).
- ws_rf_waddr  in  5  writeback destination.
- flush  in  1  pipeline flush; EX/MEM/WB contents cancelled.
- ds_ready_go  out  1  decode may issue this cycle.
- busy_vec  out  32  bit i = counter[i] != 0; bit 0 is always 0.
- stall_cycles  out  PERF_W  saturating count of hazard-stall cycles.
- sb_err  out  1  sticky: a retire was seen for a register whose counter was 0.

Behaviour:
- Reset (resetn low, asynchronous): all counters 0, busy_vec 0, stall_cycles 0, sb_err 0. With busy_vec 0, ds_ready_go = 1 while no raw hazard exists.
- Register r0: never tracked. Its counter is hardwired 0. Issues and retires addressed to r0 are ignored, and a retire to r0 never sets sb_err.
- raw_hz = (ds_rj_used & busy[ds_rj]) | (ds_rkd_used & busy[ds_rkd]).
- waw_full = ds_gr_we & (ds_dest != 0) & (counter[ds_dest] == max).
- ds_ready_go = ~raw_hz & ~waw_full. It is purely combinational, with zero latency from current state. The same-cycle retire is NOT bypassed: a register retiring this cycle still reads as busy, and the consumer issues one cycle later.
- issue = ds_valid & ds_ready_go & es_allowin & ~flush.
- inc[r] = issue & ds_gr_we & (ds_dest == r), for r != 0.
- dec[r] = ws_rf_we & (ws_rf_waddr == r) & ~flush.
- Counter update each edge:
  - inc & ~dec: +1.
  - dec & ~inc: -1 if counter > 0. If counter == 0, hold at 0 and set sb_err.
  - inc & dec: unchanged.
  - Counter increments never wrap; the waw_full gate guarantees this.
- flush: at the next edge all counters clear to 0. Issue and retire in the flush cycle are both discarded. sb_err and stall_cycles are not cleared. A flush during reset has no effect.
- stall_cycles increments when ds_valid & ~ds_ready_go & ~flush. It saturates at all-ones.
- A stall caused only by es_allowin = 0 is not counted.
- sb_err clears only on reset.
- Several registers may change in the same cycle (issue to A, retire of B). Each counter updates independently.
- Counters are written only at clock edges. Combinational inputs with no edge do not alter state.

Test Plan:
- Reset then idle: resetn low → busy_vec = 0, ds_ready_go = 1, stall_cycles = 0, sb_err = 0. Release reset, hold ds_valid = 0 for 10 cycles → still stall_cycles = 0.
- RAW stall:
  - Cycle 0: issue add.w to r5.
  - Cycle 1: decode reads r5 (ds_rj = 5, ds_rj_used = 1) → ds_ready_go = 0, busy_vec[5] = 1.
  - Cycle 3: ws_rf_we = 1, waddr = 5 → ds_ready_go stays 0 in cycle 3 and goes to 1 in cycle 4.
  - Result: stall_cycles = 3.
- WAW saturation (CNT_W = 2): issue 3 writes to r7 with no retire → counter[7] = 3, a 4th write to r7 gets ds_ready_go = 0. One retire of r7 → the 4th write issues the next cycle.
- Simultaneous inc/dec: counter[9] = 1; in one cycle issue a write to r9 and retire r9 → counter[9] stays 1 and busy_vec[9] = 1. Also issue to r10 while retiring r11 (counter 1) → busy_vec[10] = 1, busy_vec[11] = 0.
- r0 and underflow:
  - Issue with dest 0 and retire to r0 → busy_vec = 0, sb_err = 0.
  - Retire r12 with counter 0 → sb_err = 1 and remains set through a flush.
- Flush:
  - Setup: counters r3 = 2, r4 = 1. Assert flush together with issue to r3 and retire of r4.
  - Next cycle: busy_vec = 0, ds_ready_go = 1.
  - With ds_valid = 1 during the flush cycle: stall_cycles is unchanged.
